// File: rtl/clock_tick_gen_pkg.sv
// Shared types, defaults and helpers for the multi-channel clock-enable generator.
// Optional feature macro (used by the top): TICK_PHASE_ALIGN_EN.
package clock_tick_pkg;

  localparam int          NUM_CH_DEF      = 4;
  localparam int          CNT_W_DEF       = 26;
  localparam int unsigned DEFAULT_DIV_DEF = 50_000_000;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_IDX_W = ch_idx_w(NUM_CH_DEF);

  // A programmed divisor of 0 runs the channel at full rate, like 1.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clock_tick_gen_if.sv
// Control/status bundle between a game controller and clock_tick_gen.
// Optional feature macro (used by the top): TICK_PHASE_ALIGN_EN.
interface clock_tick_gen_if
  import clock_tick_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int SEL_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] ch_en;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic              div_ready;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  modport master (
    output ch_en, div_wr, div_sel, div_data,
    input  div_ready, tick, sq
  );

  modport slave (
    input  ch_en, div_wr, div_sel, div_data,
    output div_ready, tick, sq
  );

endinterface

// File: rtl/clock_tick_gen_tick_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag, tick and square wave.
// Align input is driven by the top only when TICK_PHASE_ALIGN_EN is defined.
module tick_channel
  import clock_tick_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             align,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             pending,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic [CNT_W-1:0] d_eff;
  logic             wrap;

  assign d_eff = CNT_W'(eff_div(32'(div_act)));
  // >= rather than == keeps the counter bounded even if it ever sits past the end.
  assign wrap  = (cnt >= (d_eff - CNT_W'(1)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt     <= '0;
      tick    <= 1'b0;
      sq      <= 1'b0;
      pending <= 1'b0;
      div_act <= RST_DIV;
      div_shd <= '0;
    end else if (align || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
      // Idle channel: a queued divisor lands now, a fresh one loads directly.
      if (pending) begin
        div_act <= div_shd;
        pending <= 1'b0;
      end else if (wr) begin
        div_act <= wr_data;
      end
    end else begin
      cnt  <= wrap ? '0 : cnt + CNT_W'(1);
      tick <= wrap;
      if (wrap) sq <= ~sq;
      if (wrap && pending) begin
        div_act <= div_shd;
        pending <= 1'b0;
      end else if (wr && !pending) begin
        // Mid-period writes wait in the shadow so the running period is never cut short.
        if (wrap) begin
          div_act <= wr_data;
        end else begin
          div_shd <= wr_data;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_tick_gen.sv
// Multi-channel programmable clock-enable generator (tick pulses + square waves).
// Define TICK_PHASE_ALIGN_EN to add the align input that restarts all channels in phase.
module clock_tick_gen
  import clock_tick_pkg::*;
#(
  parameter int          NUM_CH      = NUM_CH_DEF,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clock,
  input  logic             reset,
`ifdef TICK_PHASE_ALIGN_EN
  input  logic             align,
`endif
  clock_tick_gen_if.slave  bus
);

  localparam int SEL_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] sel_hit;
  logic              align_i;

`ifdef TICK_PHASE_ALIGN_EN
  assign align_i = align;
`else
  assign align_i = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range selects match no channel, so they read not-ready and write nothing.
    assign sel_hit[i] = (bus.div_sel == SEL_W'(i));

    tick_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .en      (bus.ch_en[i]),
      .align   (align_i),
      .wr      (bus.div_wr & sel_hit[i]),
      .wr_data (bus.div_data),
      .pending (pending[i]),
      .tick    (bus.tick[i]),
      .sq      (bus.sq[i])
    );
  end

  assign bus.div_ready = |(sel_hit & ~pending);

endmodule

// File: tb/tb_clock_tick_gen.sv
// Randomised scoreboard bench for clock_tick_gen against an event-time reference model.
// Build with TICK_PHASE_ALIGN_EN defined to also exercise the align input.
module tb_clock_tick_gen;
  import clock_tick_pkg::*;

  localparam int          NUM_CH  = 5;
  localparam int          CNT_W   = 8;
  localparam int unsigned DEF_DIV = 4;
  localparam int          SEL_W   = ch_idx_w(NUM_CH);

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic align = 1'b0;

  always #5 clock = ~clock;

  clock_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clock_tick_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clock (clock),
    .reset (reset),
`ifdef TICK_PHASE_ALIGN_EN
    .align (align),
`endif
    .bus   (bus)
  );

  typedef struct {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              rdy;
    longint            edge_n;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: each running channel knows the absolute edge of its next wrap.
  int unsigned m_div  [NUM_CH];
  int unsigned m_shd  [NUM_CH];
  bit          m_pend [NUM_CH];
  bit          m_run  [NUM_CH];
  bit          m_tick [NUM_CH];
  bit          m_sq   [NUM_CH];
  longint      m_next [NUM_CH];
  longint      n = 0;

  function automatic int unsigned effd(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge();
    bit acc;
    bit wrap;
    n++;
    for (int c = 0; c < NUM_CH; c++) begin
      acc = bus.div_wr && (int'(bus.div_sel) == c) && !m_pend[c];
      if (!reset) begin
        m_div[c] = DEF_DIV; m_shd[c] = 0; m_pend[c] = 0;
        m_run[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
      end else if (align || !bus.ch_en[c]) begin
        m_run[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
        if (m_pend[c]) begin
          m_div[c] = m_shd[c]; m_pend[c] = 0;
        end else if (acc) begin
          m_div[c] = int'(bus.div_data);
        end
      end else begin
        if (!m_run[c]) begin
          m_run[c]  = 1;
          m_next[c] = n + effd(m_div[c]) - 1;
        end
        wrap      = (n == m_next[c]);
        m_tick[c] = wrap;
        if (wrap) m_sq[c] = !m_sq[c];
        if (wrap && m_pend[c]) begin
          m_div[c] = m_shd[c]; m_pend[c] = 0;
        end else if (acc) begin
          if (wrap) m_div[c] = int'(bus.div_data);
          else begin
            m_shd[c] = int'(bus.div_data); m_pend[c] = 1;
          end
        end
        if (wrap) m_next[c] = n + effd(m_div[c]);
      end
    end
  endtask

  // One clock: let the edge happen, advance the model, drive the next inputs, queue the expectation.
  task automatic cyc(input bit r, input logic [NUM_CH-1:0] en, input bit w,
                     input int sel, input int data, input bit al);
    exp_t e;
    @(posedge clock);
    #1;
    model_edge();
    reset        = r;
    bus.ch_en    = en;
    bus.div_wr   = w;
    bus.div_sel  = SEL_W'(sel);
    bus.div_data = CNT_W'(data);
    align        = al;
    for (int c = 0; c < NUM_CH; c++) begin
      e.tick[c] = m_tick[c];
      e.sq[c]   = m_sq[c];
    end
    e.rdy    = (sel < NUM_CH) ? !m_pend[sel] : 1'b0;
    e.edge_n = n;
    q.push_back(e);
  endtask

  task automatic idle(input int k, input logic [NUM_CH-1:0] en);
    for (int i = 0; i < k; i++) cyc(1'b1, en, 1'b0, $urandom_range(0, 7), 0, 1'b0);
  endtask

  // Monitor: every presented output cycle is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.tick !== e.tick) begin
          failures++;
          $display("FAIL tick edge=%0d got=%b exp=%b", e.edge_n, bus.tick, e.tick);
        end
        checks++;
        if (bus.sq !== e.sq) begin
          failures++;
          $display("FAIL sq edge=%0d got=%b exp=%b", e.edge_n, bus.sq, e.sq);
        end
        checks++;
        if (bus.div_ready !== e.rdy) begin
          failures++;
          $display("FAIL div_ready edge=%0d sel=%0d got=%b exp=%b",
                   e.edge_n, bus.div_sel, bus.div_ready, e.rdy);
        end
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] en;
    bit w, r, al;
    int sel, data;
    bus.ch_en    = '0;
    bus.div_wr   = 1'b0;
    bus.div_sel  = '0;
    bus.div_data = '0;

    // Reset, then channel 0 alone at the default divisor
    cyc(1'b0, 5'b00001, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 5'b00001, 1'b0, 0, 0, 1'b0);
    idle(20, 5'b00001);
    // Mid-period rewrite of channel 0, then a second write while pending
    cyc(1'b1, 5'b00001, 1'b1, 0, 2, 1'b0);
    idle(2, 5'b00001);
    cyc(1'b1, 5'b00001, 1'b1, 0, 7, 1'b0);
    idle(12, 5'b00001);
    // Divisor 0 on channel 1: full-rate ticks
    cyc(1'b1, 5'b00011, 1'b1, 1, 0, 1'b0);
    idle(10, 5'b00011);
    // Reset while a write is pending
    cyc(1'b1, 5'b00111, 1'b1, 0, 6, 1'b0);
    cyc(1'b0, 5'b00111, 1'b0, 0, 0, 1'b0);
    idle(10, 5'b00111);
    // Channel 2 at d=5, disabled for three cycles, re-enabled
    cyc(1'b1, 5'b00111, 1'b1, 2, 5, 1'b0);
    idle(12, 5'b00111);
    idle(3, 5'b00011);
    idle(12, 5'b00111);
    // Out-of-range select
    cyc(1'b1, 5'b00111, 1'b1, 6, 1, 1'b0);
    idle(5, 5'b00111);
`ifdef TICK_PHASE_ALIGN_EN
    cyc(1'b1, 5'b00011, 1'b1, 1, 8, 1'b0);
    idle(20, 5'b00011);
    cyc(1'b1, 5'b00011, 1'b0, 0, 0, 1'b1);
    idle(24, 5'b00011);
`endif

    en = 5'b00111;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) en[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
      w    = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 7);
      data = $urandom_range(0, 11);
      r    = ($urandom_range(0, 399) != 0);
      al   = 1'b0;
`ifdef TICK_PHASE_ALIGN_EN
      al   = ($urandom_range(0, 99) == 0);
`endif
      cyc(r, en, w, sel, data, al);
    end

    idle(4, en);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
